prog_loader: RTL and testbench

Streaming program loader for the OISC8 core. Accepts a framed byte stream (from the debug UART or a host bridge), unpacks 13-bit instructions, and writes them in pairs into the three 9-bit instruction banks that the fetch stage reads. It is the write side of the instruction memory. It holds the core in reset while a load is in progress.

---
 rtl/prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streaming program loader: unpacks a framed byte stream into 13-bit instructions
// and writes them in pairs into the three 9-bit instruction banks.
module prog_loader #(
  parameter int unsigned NUMWORDS = 1024,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(NUMWORDS)-1:0] wr_addr,
  output logic [26:0]                 wr_data,
  output logic                        wr_en,
  output logic                        cpu_rst,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned AW  = $clog2(NUMWORDS);
  localparam logic [16:0] CAP = 17'(2 * NUMWORDS);

  typedef enum logic [3:0] {
    IDLE, LEN_H, LEN_L, P_LO, P_HI, WRITE, CHECK, DONE, ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      lo_q, lo_d;
  logic [12:0]     pair_q, pair_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [26:0]     data_q, data_d;
  logic            wr_en_q, wr_en_d;
  logic            in_ready_q, in_ready_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            xfer;
  logic [15:0]     n_full;
  logic [12:0]     instr;
  logic [15:0]     cnt_inc;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      lo_q       <= '0;
      pair_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      in_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      lo_q       <= lo_d;
      pair_q     <= pair_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame parser, instruction packing and next-cycle outputs
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    lo_d      = lo_q;
    pair_d    = pair_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;

    xfer    = in_valid & in_ready_q;
    n_full  = {len_q[15:8], in_data};
    instr   = {in_data[4:0], lo_q};
    cnt_inc = 16'(cnt_q + 16'd1);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (xfer && in_data == MAGIC) begin
          state_d   = LEN_H;
          done_d    = 1'b0;
          err_d     = 1'b0;
          chk_d     = '0;
          cpu_rst_d = 1'b1;
        end
      end
      LEN_H: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = LEN_L;
        end
      end
      LEN_L: begin
        if (xfer) begin
          len_d = n_full;
          cnt_d = '0;
          if ({1'b0, n_full} > CAP) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = P_LO;
          end
        end
      end
      P_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          chk_d   = chk_q + in_data;
          state_d = P_HI;
        end
      end
      P_HI: begin
        if (xfer) begin
          chk_d = chk_q + in_data;
          if (in_data[7:5] != 3'b000) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_q[0]) begin
              addr_d  = AW'(cnt_q >> 1);
              data_d  = {instr, pair_q, 1'b0};
              state_d = WRITE;
            end else if (cnt_inc == len_q) begin
              // Odd-length frame: the trailing even instruction has no partner
              addr_d  = AW'(cnt_q >> 1);
              data_d  = {13'd0, instr, 1'b0};
              state_d = WRITE;
            end else begin
              pair_d  = instr;
              state_d = P_LO;
            end
          end
        end
      end
      WRITE: begin
        state_d = (cnt_q == len_q) ? CHECK : P_LO;
      end
      CHECK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != WRITE);
    wr_en_d    = (state_d == WRITE);
  end

  assign in_ready = in_ready_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign wr_en    = wr_en_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected row writes plus
// per-scenario checks of the frame status outputs.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  wr_addr;
  logic [26:0] wr_data;
  logic        wr_en;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_seen = 0;
  bit gap_en = 0;
  logic [36:0] exp_q[$];
  logic [12:0] ins_mem [0:2047];

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every wr_en pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      logic [36:0] e;
      wr_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%0h data=%07h, no write expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e)
          $display("FAIL row_write got addr=%0h data=%07h, want addr=%0h data=%07h",
                   wr_addr, wr_data, e[36:27], e[26:0]);
        else pass_cnt++;
      end
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL write_stall in_ready=%b want 0", in_ready);
      else pass_cnt++;
    end
  end

  // Send one byte, waiting (bounded) for in_ready; called and returns at a negedge
  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    if (gap_en) begin
      while ($urandom_range(0, 1) == 1 && tries < 3) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
        tries++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (!in_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL ready_timeout in_ready=%b want 1 within 8 cycles", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Send a frame of ins_mem[0:n-1]; pushes the expected packed rows first
  task automatic send_frame(input int n, input logic [7:0] chk_flip);
    logic [7:0] sum = 8'd0;
    logic [15:0] nn = 16'(n);
    for (int k = 0; k < n; k += 2) begin
      logic [26:0] d;
      d = 27'(ins_mem[k]) << 1;
      if (k + 1 < n) d = d | (27'(ins_mem[k + 1]) << 14);
      exp_q.push_back({10'(k / 2), d});
    end
    send_byte(8'hA5);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int k = 0; k < n; k++) begin
      logic [7:0] lo, hi;
      lo = ins_mem[k][7:0];
      hi = {3'b000, ins_mem[k][12:8]};
      sum = sum + lo + hi;
      send_byte(lo);
      send_byte(hi);
    end
    send_byte(sum ^ chk_flip);
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic c);
    total_cnt++;
    if ({done, err, cpu_rst} !== {d, e, c})
      $display("FAIL %s done/err/cpu_rst=%b%b%b want %b%b%b", name, done, err, cpu_rst, d, e, c);
    else pass_cnt++;
  endtask

  task automatic check_writes(input string name, input int w0, input int n);
    total_cnt++;
    if (wr_seen != w0 + n || exp_q.size() != 0)
      $display("FAIL %s writes=%0d pending=%0d want writes=%0d pending=0",
               name, wr_seen - w0, exp_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic check_reset_vals(input string name);
    total_cnt++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err} !== {1'b1, 1'b0, 10'd0, 27'd0, 3'b000})
      $display("FAIL %s rdy=%b wen=%b addr=%0h data=%0h rst=%b done=%b err=%b want 1 0 0 0 0 0 0",
               name, in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset_release");
  endtask

  task automatic test_spec_frame(input logic [7:0] chk, input bit good);
    int w0 = wr_seen;
    logic [7:0] bytes [0:9];
    bytes = '{8'hA5, 8'h00, 8'h03, 8'h23, 8'h01, 8'hBC, 8'h1A, 8'h05, 8'h00, 8'hFF};
    bytes[9] = chk;
    exp_q.push_back({10'd0, 27'h6AF0246});
    exp_q.push_back({10'd1, 27'h000000A});
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i]);
      if (i == 0) check_status("cpu_rst_after_magic", 1'b0, 1'b0, 1'b1);
      if (i == 8) check_status("cpu_rst_before_chk", 1'b0, 1'b0, 1'b1);
    end
    if (good) check_status("good_frame_done", 1'b1, 1'b0, 1'b0);
    else      check_status("bad_chk_error", 1'b0, 1'b1, 1'b1);
    idle(3);
    check_writes(good ? "spec_frame_rows" : "bad_chk_rows", w0, 2);
  endtask

  task automatic test_reserved_bits();
    int w0 = wr_seen;
    logic [7:0] bytes [0:7];
    bytes = '{8'hA5, 8'h00, 8'h01, 8'h10, 8'h20, 8'h23, 8'h00, 8'h33};
    for (int i = 0; i < 5; i++) send_byte(bytes[i]);
    check_status("reserved_hi_error", 1'b0, 1'b1, 1'b1);
    for (int i = 5; i < 8; i++) send_byte(bytes[i]);
    idle(2);
    check_status("reserved_trailing_ignored", 1'b0, 1'b1, 1'b1);
    check_writes("reserved_no_write", w0, 0);
  endtask

  task automatic test_len_overflow();
    int w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h01);
    check_status("len_overflow_error", 1'b0, 1'b1, 1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    check_writes("len_overflow_no_write", w0, 0);
  endtask

  task automatic test_zero_len();
    int w0 = wr_seen;
    logic [7:0] bytes [0:6];
    bytes = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) send_byte(bytes[i]);
    check_status("zero_len_done", 1'b1, 1'b0, 1'b0);
    idle(2);
    check_writes("zero_len_no_write", w0, 0);
  endtask

  task automatic test_mid_reset();
    int w0 = wr_seen;
    logic [7:0] bytes [0:7];
    bytes = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h01, 8'h22, 8'h02, 8'h33};
    exp_q.push_back({10'd0, 27'({13'h0222, 13'h0111, 1'b0})});
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    check_status("mid_frame_loading", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_frame_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_writes("mid_reset_partial_rows", w0, 1);
    w0 = wr_seen;
    for (int k = 0; k < 4; k++) ins_mem[k] = 13'($urandom);
    send_frame(4, 8'h00);
    check_status("after_reset_frame_done", 1'b1, 1'b0, 1'b0);
    idle(2);
    check_writes("after_reset_rows", w0, 2);
  endtask

  task automatic test_random_valid();
    int w0 = wr_seen;
    gap_en = 1;
    for (int k = 0; k < 6; k++) ins_mem[k] = 13'($urandom);
    ins_mem[0][7:0] = 8'hA5;
    send_frame(6, 8'h00);
    gap_en = 0;
    check_status("random_valid_done", 1'b1, 1'b0, 1'b0);
    idle(2);
    check_writes("random_valid_rows", w0, 3);
  endtask

  task automatic test_back_to_back();
    int w0 = wr_seen;
    for (int k = 0; k < 5; k++) ins_mem[k] = 13'($urandom);
    send_frame(5, 8'h00);
    check_status("b2b_first_done", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2048; k++) ins_mem[k] = 13'($urandom);
    send_frame(2048, 8'h00);
    check_status("full_capacity_done", 1'b1, 1'b0, 1'b0);
    idle(2);
    check_writes("b2b_rows", w0, 3 + 1024);
  endtask

  initial begin
    test_reset();
    test_spec_frame(8'hFF, 1'b1);
    test_spec_frame(8'hFE, 1'b0);
    test_reserved_bits();
    test_len_overflow();
    test_zero_len();
    test_mid_reset();
    test_random_valid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
